// File: rtl/pong_ball_ctl.sv
// rtl/pong_ball_ctl.sv - per-frame pong ball position generator with wall/paddle bounce and scoring
// Optional BALL_SPEEDUP_EN: each paddle hit raises the step by one, capped at MAX_STEP.
module pong_ball_ctl #(
   parameter int SCREEN_W     = 800,
   parameter int SCREEN_H     = 600,
   parameter int BALL_W       = 48,
   parameter int BALL_H       = 64,
   parameter int STEP         = 4,
   parameter int MAX_STEP     = 8,
   parameter int SERVE_FRAMES = 60,
   parameter int PAD_L_X      = 16,
   parameter int PAD_R_X      = 768,
   parameter int PAD_W        = 16,
   parameter int PAD_H        = 96
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        vblnk_in,
   input  logic        start,
   input  logic [11:0] pad_l_y,
   input  logic [11:0] pad_r_y,
   output logic [11:0] x_pos,
   output logic [11:0] y_pos,
   output logic        hit,
   output logic        score_l,
   output logic        score_r,
   output logic [1:0]  state
);
   localparam int CW = $clog2(SERVE_FRAMES + 1);
   localparam logic [11:0] X_C = 12'((SCREEN_W - BALL_W) / 2);
   localparam logic [11:0] Y_C = 12'((SCREEN_H - BALL_H) / 2);
   localparam logic signed [12:0] Y_MAX = 13'(SCREEN_H - BALL_H);
   localparam logic signed [12:0] X_LIM_L = 13'(PAD_L_X + PAD_W);
   localparam logic signed [12:0] X_LIM_R = 13'(PAD_R_X - BALL_W);

   typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, MOVE = 2'd2, SCORED = 2'd3} state_t;

   state_t          state_q, state_d;
   logic            vblnk_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [11:0]     x_q, x_d, y_q, y_d;
   logic            dx_q, dx_d, dy_q, dy_d;  // 1 = positive direction
   logic            hit_q, hit_d, score_l_q, score_l_d, score_r_q, score_r_d;
   logic            tick;
   logic signed [12:0] st_s, xn, yn;
   logic [12:0]     y_bot;
   logic            ovl_l, ovl_r;

`ifdef BALL_SPEEDUP_EN
   logic [7:0] step_q, step_d;
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) step_q <= 8'(STEP);
      else        step_q <= step_d;
   end
`else
   logic [7:0] step_q;
   assign step_q = 8'(STEP);
`endif

   assign tick  = vblnk_in & ~vblnk_q;
   assign st_s  = $signed({5'd0, step_q});
   assign xn    = dx_q ? $signed({1'b0, x_q}) + st_s : $signed({1'b0, x_q}) - st_s;
   assign yn    = dy_q ? $signed({1'b0, y_q}) + st_s : $signed({1'b0, y_q}) - st_s;
   // Overlap uses the pre-move y so the paddle sees where the ball was drawn
   assign y_bot = {1'b0, y_q} + 13'(BALL_H);
   assign ovl_l = (y_bot > {1'b0, pad_l_y}) && ({1'b0, y_q} < {1'b0, pad_l_y} + 13'(PAD_H));
   assign ovl_r = (y_bot > {1'b0, pad_r_y}) && ({1'b0, y_q} < {1'b0, pad_r_y} + 13'(PAD_H));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      x_d       = x_q;
      y_d       = y_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      hit_d     = 1'b0;
      score_l_d = 1'b0;
      score_r_d = 1'b0;
`ifdef BALL_SPEEDUP_EN
      step_d    = step_q;
`endif
      case (state_q)
         IDLE: begin
            x_d = X_C;
            y_d = Y_C;
            if (start) begin
               state_d = SERVE;
               cnt_d   = '0;
`ifdef BALL_SPEEDUP_EN
               step_d  = 8'(STEP);
`endif
            end
         end
         SERVE: begin
            x_d = X_C;
            y_d = Y_C;
            if (tick) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(SERVE_FRAMES - 1)) state_d = MOVE;
            end
         end
         MOVE: begin
            if (tick) begin
               if (yn < 0) begin
                  y_d  = 12'd0;
                  dy_d = 1'b1;
               end else if (yn > Y_MAX) begin
                  y_d  = Y_MAX[11:0];
                  dy_d = 1'b0;
               end else begin
                  y_d = yn[11:0];
               end
               if ((!dx_q && xn < X_LIM_L) || (dx_q && xn > X_LIM_R)) begin
                  if (dx_q ? ovl_r : ovl_l) begin
                     x_d   = dx_q ? X_LIM_R[11:0] : X_LIM_L[11:0];
                     dx_d  = ~dx_q;
                     hit_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
                     step_d = (step_q >= 8'(MAX_STEP)) ? step_q : step_q + 8'd1;
`endif
                  end else begin
                     // A miss discards this frame's y move and serves toward the loser
                     y_d       = y_q;
                     dy_d      = dy_q;
                     dx_d      = ~dx_q;
                     score_l_d = dx_q;
                     score_r_d = ~dx_q;
                     state_d   = SCORED;
                  end
               end else begin
                  x_d = xn[11:0];
               end
            end
         end
         SCORED: begin
            state_d = IDLE;
            x_d     = X_C;
            y_d     = Y_C;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         vblnk_q   <= 1'b0;
         cnt_q     <= '0;
         x_q       <= X_C;
         y_q       <= Y_C;
         dx_q      <= 1'b1;
         dy_q      <= 1'b1;
         hit_q     <= 1'b0;
         score_l_q <= 1'b0;
         score_r_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         vblnk_q   <= vblnk_in;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         hit_q     <= hit_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
      end
   end

   assign x_pos   = x_q;
   assign y_pos   = y_q;
   assign hit     = hit_q;
   assign score_l = score_l_q;
   assign score_r = score_r_q;
   assign state   = state_q;
endmodule

// File: tb/tb_pong_ball_ctl.sv
// tb/tb_pong_ball_ctl.sv - directed self-checking bench for pong_ball_ctl
module tb_pong_ball_ctl;
   logic        pclk = 1'b0;
   logic        rst_n, vblnk_in, start;
   logic [11:0] pad_l_y, pad_r_y;
   logic [11:0] x_pos, y_pos;
   logic        hit, score_l, score_r;
   logic [1:0]  state;
   int          errors = 0;
   int          checks = 0;

`ifdef BALL_SPEEDUP_EN
   localparam int X88 = 715;
   localparam int Y88 = 455;
`else
   localparam int X88 = 716;
   localparam int Y88 = 456;
`endif

   pong_ball_ctl dut (
      .pclk(pclk), .rst_n(rst_n), .vblnk_in(vblnk_in), .start(start),
      .pad_l_y(pad_l_y), .pad_r_y(pad_r_y), .x_pos(x_pos), .y_pos(y_pos),
      .hit(hit), .score_l(score_l), .score_r(score_r), .state(state)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic rise();
      vblnk_in = 1'b0;
      @(posedge pclk); #1;
      vblnk_in = 1'b1;
      @(posedge pclk); #1;
   endtask

   task automatic rises(input int n);
      repeat (n) rise();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge pclk); #1;
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      @(posedge pclk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; vblnk_in = 1'b0; start = 1'b0; pad_l_y = 12'd0; pad_r_y = 12'd0;
      repeat (3) @(posedge pclk);
      #1;
      check("rst_x", 32'(x_pos), 376);
      check("rst_y", 32'(y_pos), 268);
      check("rst_state", 32'(state), 0);
      check("rst_pulses", {29'd0, hit, score_l, score_r}, 0);
      rst_n = 1'b1;

      pulse_start();
      check("serve_state", 32'(state), 1);
      rises(59);
      check("serve_59", 32'(state), 1);
      rise();
      check("serve_60_state", 32'(state), 2);
      check("serve_60_x", 32'(x_pos), 376);
      check("serve_60_y", 32'(y_pos), 268);
      rise();
      check("move1_x", 32'(x_pos), 380);
      check("move1_y", 32'(y_pos), 272);
      repeat (999) @(posedge pclk);
      #1;
      check("hold_x", 32'(x_pos), 380);
      check("hold_y", 32'(y_pos), 272);
      rises(2);
      check("move3_x", 32'(x_pos), 388);

      rst_n = 1'b0;
      #1;
      check("amid_x", 32'(x_pos), 376);
      check("amid_y", 32'(y_pos), 268);
      check("amid_state", 32'(state), 0);
      check("amid_pulses", {29'd0, hit, score_l, score_r}, 0);
      @(posedge pclk); #1;
      rst_n = 1'b1;

      pulse_start();
      rises(60);
      rises(66);
      rise();
      check("r67_y", 32'(y_pos), 536);
      check("r67_x", 32'(x_pos), 644);
      rise();
      check("r68_y", 32'(y_pos), 536);
      rise();
      check("r69_y", 32'(y_pos), 532);
      check("r69_x", 32'(x_pos), 652);
      pad_r_y = 12'd440;
      rises(16);
      rise();
      check("r86_x", 32'(x_pos), 720);
      check("r86_y", 32'(y_pos), 464);
      rise();
      check("r87_hit", 32'(hit), 1);
      check("r87_x", 32'(x_pos), 720);
      check("r87_y", 32'(y_pos), 460);
      check("r87_score", {30'd0, score_l, score_r}, 0);
      @(posedge pclk); #1;
      check("hit_fall", 32'(hit), 0);
      rise();
      check("r88_x", 32'(x_pos), X88);
      check("r88_y", 32'(y_pos), Y88);

      do_reset();
      pad_r_y = 12'd0;
      pulse_start();
      rises(60);
      rises(86);
      check("miss86_x", 32'(x_pos), 720);
      rise();
      check("miss_score_l", 32'(score_l), 1);
      check("miss_state", 32'(state), 3);
      check("miss_hit_r", {30'd0, hit, score_r}, 0);
      check("miss_y_kept", 32'(y_pos), 464);
      @(posedge pclk); #1;
      check("idle_state", 32'(state), 0);
      check("idle_x", 32'(x_pos), 376);
      check("idle_y", 32'(y_pos), 268);
      check("score_fall", 32'(score_l), 0);
      pulse_start();
      rises(60);
      check("reserve_state", 32'(state), 2);
      rise();
      check("reserve_x", 32'(x_pos), 372);
      check("reserve_y", 32'(y_pos), 264);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pong_ball_ctl.md
# pong_ball_ctl

Per-frame ball position generator for the PONG video pipeline. It sits directly upstream of the rectangle drawing stage and drives that stage's `x_pos`/`y_pos` inputs. The ball moves once per frame, at the start of vertical blanking. The block handles wall bounces, paddle hits, misses with score pulses, and the serve sequence, so the ball position never changes while visible lines are being drawn.

## Interface
Parameters:
- `SCREEN_W`, 800: active width in pixels
- `SCREEN_H`, 600: active height in pixels
- `BALL_W`, 48: ball width; must match the drawing stage
- `BALL_H`, 64: ball height; must match the drawing stage
- `STEP`, 4: pixels moved per frame on each axis
- `MAX_STEP`, 8: step ceiling; used only with speed-up
- `SERVE_FRAMES`, 60: frames waited in SERVE before motion starts
- `PAD_L_X`, 16: left paddle left edge
- `PAD_R_X`, 768: right paddle left edge
- `PAD_W`, 16: paddle width
- `PAD_H`, 96: paddle height

Ports:
- `pclk` in 1: pixel clock, the only clock
- `rst_n` in 1: asynchronous, active-low reset
- `vblnk_in` in 1: vertical blank from the timing generator
- `start` in 1: level; starts a serve when the block is in IDLE
- `pad_l_y` in 12: left paddle top y
- `pad_r_y` in 12: right paddle top y
- `x_pos` out 12: ball left x, registered
- `y_pos` out 12: ball top y, registered
- `hit` out 1: one-cycle pulse on a paddle hit
- `score_l` out 1: one-cycle pulse when the left player scores (ball missed on the right)
- `score_r` out 1: one-cycle pulse when the right player scores (ball missed on the left)
- `state` out 2: IDLE=0, SERVE=1, MOVE=2, SCORED=3

## Operation
- **Frame tick.** `vblnk_q` is a registered copy of `vblnk_in`. `tick = vblnk_in & ~vblnk_q`, giving exactly one tick per frame. Holding `vblnk_in` high never produces a second tick.
- **IDLE.**
  - Ball is centred: `x_pos=(SCREEN_W-BALL_W)/2` (376), `y_pos=(SCREEN_H-BALL_H)/2` (268).
  - `start=1` moves the FSM to SERVE and clears the frame counter.
- **SERVE.**
  - Ball stays centred.
  - Each tick increments the frame counter.
  - On the tick that makes the count equal `SERVE_FRAMES`, the FSM enters MOVE. No movement happens on that tick.
- **MOVE, on each tick.** Compute next positions in 13-bit signed arithmetic: `xn = x + dx*step`, `yn = y + dy*step`.
  - Y axis: if `yn < 0`, set `y=0` and `dy=+1`. If `yn > SCREEN_H-BALL_H` (536), set `y=536` and `dy=-1`. Otherwise `y=yn`.
  - Left side, when `dx<0` and `xn < PAD_L_X+PAD_W` (32):
    - Overlap test uses the pre-update y: `y+BALL_H > pad_l_y` and `y < pad_l_y+PAD_H`.
    - Overlap: set `x=32`, `dx=+1`, pulse `hit`.
    - No overlap: pulse `score_r` and enter SCORED. The y update is discarded.
  - Right side, when `dx>0` and `xn > PAD_R_X-BALL_W` (720): the same rule applies with `pad_r_y`. Overlap sets `x=720` and `dx=-1`; a miss pulses `score_l`.
  - Otherwise `x=xn`.
  - A Y bounce and a paddle hit on the same tick are both applied. A score takes priority over any bounce.
- **SCORED.**
  - Lasts one cycle, then returns to IDLE with the ball centred.
  - Next serve direction: after `score_l`, `dx=-1`; after `score_r`, `dx=+1`. `dy` is kept.
- `start` is ignored outside IDLE.

## Timing
- **Reset values** while `rst_n=0` (asynchronous):
  - `state=IDLE`, `x_pos=376`, `y_pos=268`
  - `hit=0`, `score_l=0`, `score_r=0`
  - `dx=+1`, `dy=+1`, `step=STEP`, frame counter 0, `vblnk_q=0`
- **Reset mid-operation:** same values are forced immediately, with no pending pulse.
- **Latency:** `x_pos`/`y_pos` update at the `pclk` edge where `vblnk_in=1` is first sampled. The new values are visible one cycle later and then hold for the whole frame.
- **Pulses:** `hit`, `score_l` and `score_r` are registered, fall on the next edge, and never assert together.
- **Inputs:** `pad_l_y` and `pad_r_y` are sampled only on tick cycles. They are quasi-static and need no synchronizer.

## Configuration
- `BALL_SPEEDUP_EN` defined: each paddle hit does `step = min(step+1, MAX_STEP)`, and entering SERVE resets `step` to `STEP`.
- `BALL_SPEEDUP_EN` undefined: `step` is constantly `STEP` and `MAX_STEP` is unused.

## Test plan
All scenarios use the default parameters.
- **Reset:** pulse `rst_n` low mid-MOVE → at once `x_pos=376`, `y_pos=268`, `state=0`, all pulses 0.
- **Serve and first move:** `start=1`, then 60 vblank rises → `state=2` with the ball still at (376,268). The next rise gives (380,272).
- **Wall bounce:** continue without paddles in the way.
  - Rise 67 after entering MOVE gives `y=536`.
  - Rise 68 gives `y=536` and `dy=-1`.
  - Rise 69 gives `y=532`.
- **Paddle hit:** `pad_r_y=440`.
  - Rise 86 gives `x=720`, `y=464`.
  - Rise 87 gives `x=720`, a one-cycle `hit`, and `dx=-1`.
  - Rise 88 gives `x=716`.
- **Miss:** `pad_r_y=0`, same sequence → on rise 87 `score_l` pulses for one cycle, then `state=3` for one cycle, then IDLE at (376,268). The next serve moves the ball left.
- **Tick qualification:** hold `vblnk_in` high for 1000 cycles → exactly one position update. With `BALL_SPEEDUP_EN` defined, the hit in the paddle-hit scenario makes the next step 5, so `x=715`.
